kreg_bank: RTL and testbench

- Parametrised key store holding NSLOT session slots; each slot has a KEY bank (host-provisioned key) and a PSK bank (host- or ECDH-provisioned).
- Host accesses it through a word-wide register port.
- Presents the selected slot's key and psk to the crypto datapath with per-bank valid flags.
- Adds a sequential zeroization engine, per-word provisioning tracking and an ECDH update handshake.

---
 rtl/kreg_pkg.sv | 30 +++
 rtl/kreg_zeroize_fsm.sv | 84 ++++++++
 rtl/kreg_bank.sv | 152 +++++++++++++++
 tb/tb_kreg_bank.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kreg_pkg.sv
// Shared types and width helpers for the kreg_bank key store.
// Storage word address layout is {slot, bank, word}; word 0 is the most
// significant word of a key.
package kreg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ZSLOT = 2'd1,
    ZALL  = 2'd2
  } zstate_t;

  localparam logic BANK_KEY = 1'b0;
  localparam logic BANK_PSK = 1'b1;

  // Slot index width.
  function automatic int unsigned sw_of(input int unsigned nslot);
    return $clog2(nslot);
  endfunction

  // Word-within-bank index width (wpk = words per key).
  function automatic int unsigned aw_of(input int unsigned wpk);
    return $clog2(wpk);
  endfunction

  // Full storage word address width: slot + bank bit + word.
  function automatic int unsigned taw_of(input int unsigned nslot, input int unsigned wpk);
    return sw_of(nslot) + 1 + aw_of(wpk);
  endfunction

endpackage

// File: rtl/kreg_zeroize_fsm.sv
// Sequential zeroization engine for kreg_bank.
// Sweeps one storage word per cycle: 2*WPK words for a single slot, or the
// whole store for ZALL. Reset forces a full ZALL sweep.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   zeroize_req/all/slot     request pulse, all-slots select, target slot
//   busy                     sweep in progress
//   zdone                    one-cycle pulse after the last word is cleared
//   accept                   request accepted this cycle
//   clr_we, clr_addr         storage clear strobe and word address
//   mclr_slot                per-slot mask-clear vector (valid on accept)
module kreg_zeroize_fsm
  import kreg_pkg::*;
#(
  parameter  int unsigned NSLOT = 8,
  parameter  int unsigned WPK   = 8,
  localparam int unsigned SW    = sw_of(NSLOT),
  localparam int unsigned AW    = aw_of(WPK),
  localparam int unsigned TAW   = taw_of(NSLOT, WPK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             zeroize_req,
  input  logic             zeroize_all,
  input  logic [SW-1:0]    zeroize_slot,
  output logic             busy,
  output logic             zdone,
  output logic             accept,
  output logic             clr_we,
  output logic [TAW-1:0]   clr_addr,
  output logic [NSLOT-1:0] mclr_slot
);

  zstate_t        state_q, state_d;
  logic [TAW-1:0] cnt_q;
  logic [SW-1:0]  zslot_q;
  logic           last;

  // ZSLOT only uses the low {bank,word} bits of the counter.
  assign last = ((state_q == ZSLOT) && (&cnt_q[AW:0])) ||
                ((state_q == ZALL)  && (&cnt_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ZALL;
      cnt_q   <= '0;
      zslot_q <= '0;
      zdone   <= 1'b0;
    end else begin
      state_q <= state_d;
      zdone   <= last;
      if ((state_q != IDLE) && !last) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
      if (accept) begin
        zslot_q <= zeroize_slot;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (zeroize_req) state_d = zeroize_all ? ZALL : ZSLOT;
      ZSLOT, ZALL: if (last)        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    accept    = (state_q == IDLE) && zeroize_req;
    clr_we    = busy;
    clr_addr  = (state_q == ZSLOT) ? {zslot_q, cnt_q[AW:0]} : cnt_q;
    mclr_slot = '0;
    if (accept) begin
      if (zeroize_all) mclr_slot = '1;
      else             mclr_slot[zeroize_slot] = 1'b1;
    end
  end

endmodule

// File: rtl/kreg_bank.sv
// Session key store: NSLOT slots, each with a KEY and a PSK bank of WPK words.
// Host word-wide write/read port, registered key/psk outputs for the active
// slot with per-bank valid flags, ECDH PSK update handshake and zeroization.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   wr_en/slot/bank/addr/d, wr_err  host write port, dropped-write pulse
//   rd_slot/bank/addr, rd_d         host read port (1-cycle latency)
//   ssid, ssid_vld                  active slot select
//   k, psk, k_vld, psk_vld          registered selected key material
//   ecdh_sk_update, ecdh_sk, ecdh_ack  ECDH PSK provisioning handshake
//   zeroize_req/all/slot, busy, zdone  zeroization control
module kreg_bank
  import kreg_pkg::*;
#(
  parameter  int unsigned NSLOT     = 8,
  parameter  int unsigned KW        = 256,
  parameter  int unsigned DW        = 32,
  parameter  int unsigned RD_KEY_EN = 1,
  localparam int unsigned WPK       = KW / DW,
  localparam int unsigned SW        = sw_of(NSLOT),
  localparam int unsigned AW        = aw_of(WPK)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_slot,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_d,
  output logic          wr_err,
  input  logic [SW-1:0] rd_slot,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_d,
  input  logic [SW-1:0] ssid,
  input  logic          ssid_vld,
  output logic [KW-1:0] k,
  output logic [KW-1:0] psk,
  output logic          k_vld,
  output logic          psk_vld,
  input  logic          ecdh_sk_update,
  input  logic [KW-1:0] ecdh_sk,
  output logic          ecdh_ack,
  input  logic          zeroize_req,
  input  logic          zeroize_all,
  input  logic [SW-1:0] zeroize_slot,
  output logic          busy,
  output logic          zdone
);

  localparam int unsigned TAW   = taw_of(NSLOT, WPK);
  localparam int unsigned DEPTH = NSLOT * 2 * WPK;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] mask_q, mask_d;

  logic             accept, clr_we;
  logic [TAW-1:0]   clr_addr;
  logic [NSLOT-1:0] mclr_slot;

  logic             host_ok, ecdh_ok, k_ok, psk_ok;
  logic [TAW-1:0]   wr_a, rd_a;
  logic [KW-1:0]    k_sel, psk_sel;

  kreg_zeroize_fsm #(
    .NSLOT (NSLOT),
    .WPK   (WPK)
  ) u_zfsm (
    .clk          (clk),
    .rst          (rst),
    .zeroize_req  (zeroize_req),
    .zeroize_all  (zeroize_all),
    .zeroize_slot (zeroize_slot),
    .busy         (busy),
    .zdone        (zdone),
    .accept       (accept),
    .clr_we       (clr_we),
    .clr_addr     (clr_addr),
    .mclr_slot    (mclr_slot)
  );

  assign wr_a = {wr_slot, wr_bank, wr_addr};
  assign rd_a = {rd_slot, rd_bank, rd_addr};

  // Arbitration: zeroize engine > host write > ECDH.
  assign host_ok = !rst && wr_en && !busy && !accept;
  assign ecdh_ok = !rst && ecdh_sk_update && !busy && !zeroize_req && !wr_en && ssid_vld;

  // Storage is never reset; the reset-forced ZALL sweep clears it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (host_ok) begin
      mem[wr_a] <= wr_d;
    end else if (ecdh_ok) begin
      for (int unsigned w = 0; w < WPK; w++) begin
        mem[{ssid, BANK_PSK, AW'(w)}] <= ecdh_sk[KW-1-w*DW -: DW];
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      if (mclr_slot[s]) mask_d[s*2*WPK +: 2*WPK] = '0;
    end
    if (host_ok) mask_d[wr_a] = 1'b1;
    if (ecdh_ok) begin
      for (int unsigned w = 0; w < WPK; w++) begin
        mask_d[{ssid, BANK_PSK, AW'(w)}] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end

  assign k_ok   = ssid_vld && (&mask_q[{ssid, BANK_KEY, {AW{1'b0}}} +: WPK]);
  assign psk_ok = ssid_vld && (&mask_q[{ssid, BANK_PSK, {AW{1'b0}}} +: WPK]);

  always_comb begin
    k_sel   = '0;
    psk_sel = '0;
    for (int unsigned w = 0; w < WPK; w++) begin
      k_sel[KW-1-w*DW -: DW]   = mem[{ssid, BANK_KEY, AW'(w)}];
      psk_sel[KW-1-w*DW -: DW] = mem[{ssid, BANK_PSK, AW'(w)}];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_d     <= '0;
      k        <= '0;
      psk      <= '0;
      k_vld    <= 1'b0;
      psk_vld  <= 1'b0;
      wr_err   <= 1'b0;
      ecdh_ack <= 1'b0;
    end else begin
      rd_d     <= ((rd_bank == BANK_KEY) && (RD_KEY_EN == 0)) ? '0 : mem[rd_a];
      k        <= k_ok   ? k_sel   : '0;
      psk      <= psk_ok ? psk_sel : '0;
      k_vld    <= k_ok;
      psk_vld  <= psk_ok;
      wr_err   <= wr_en && !host_ok;
      ecdh_ack <= ecdh_ok;
    end
  end

endmodule

// File: tb/tb_kreg_bank.sv
// Self-checking bench for kreg_bank: two instances share stimulus, one with
// host KEY reads enabled (dut0) and one with them disabled (dut1).
module tb_kreg_bank;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en, wr_bank, rd_bank, ssid_vld, ecdh_sk_update;
  logic         zeroize_req, zeroize_all;
  logic [2:0]   wr_slot, wr_addr, rd_slot, rd_addr, ssid, zeroize_slot;
  logic [31:0]  wr_d;
  logic [255:0] ecdh_sk;

  logic         wr_err0, wr_err1, k_vld0, k_vld1, psk_vld0, psk_vld1;
  logic         ecdh_ack0, ecdh_ack1, busy0, busy1, zdone0, zdone1;
  logic [31:0]  rd_d0, rd_d1;
  logic [255:0] k0, k1, psk0, psk1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] ref_mem [128];
  bit   [127:0] ref_mask;

  typedef struct packed {
    logic [31:0] e0;
    logic [31:0] e1;
  } rd_exp_t;
  rd_exp_t rdq[$];

  always #5 clk = ~clk;

  kreg_bank #(.NSLOT(8), .KW(256), .DW(32), .RD_KEY_EN(1)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_slot(wr_slot), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_d(wr_d), .wr_err(wr_err0), .rd_slot(rd_slot),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_d(rd_d0), .ssid(ssid),
    .ssid_vld(ssid_vld), .k(k0), .psk(psk0), .k_vld(k_vld0), .psk_vld(psk_vld0),
    .ecdh_sk_update(ecdh_sk_update), .ecdh_sk(ecdh_sk), .ecdh_ack(ecdh_ack0),
    .zeroize_req(zeroize_req), .zeroize_all(zeroize_all),
    .zeroize_slot(zeroize_slot), .busy(busy0), .zdone(zdone0)
  );

  kreg_bank #(.NSLOT(8), .KW(256), .DW(32), .RD_KEY_EN(0)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_slot(wr_slot), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_d(wr_d), .wr_err(wr_err1), .rd_slot(rd_slot),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_d(rd_d1), .ssid(ssid),
    .ssid_vld(ssid_vld), .k(k1), .psk(psk1), .k_vld(k_vld1), .psk_vld(psk_vld1),
    .ecdh_sk_update(ecdh_sk_update), .ecdh_sk(ecdh_sk), .ecdh_ack(ecdh_ack1),
    .zeroize_req(zeroize_req), .zeroize_all(zeroize_all),
    .zeroize_slot(zeroize_slot), .busy(busy1), .zdone(zdone1)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx(input int s, input int b, input int w);
    return s * 16 + b * 8 + w;
  endfunction

  function automatic logic [255:0] exp_bank(input int s, input int b);
    logic [255:0] r;
    bit           all;
    r   = '0;
    all = 1'b1;
    for (int w = 0; w < 8; w++) begin
      if (!ref_mask[idx(s, b, w)]) all = 1'b0;
      r[255-w*32 -: 32] = ref_mem[idx(s, b, w)];
    end
    return all ? r : '0;
  endfunction

  task automatic model_clear_slot(input int s);
    for (int i = 0; i < 16; i++) begin
      ref_mem[s*16+i]  = '0;
      ref_mask[s*16+i] = 1'b0;
    end
  endtask

  task automatic model_clear_all();
    for (int s = 0; s < 8; s++) model_clear_slot(s);
  endtask

  // Each edge retires at most one read issued before it.
  task automatic tick();
    rd_exp_t e;
    @(posedge clk);
    #1;
    if (rdq.size() > 0) begin
      e = rdq.pop_front();
      check("rd_d_dut0", rd_d0, e.e0);
      check("rd_d_dut1", rd_d1, e.e1);
    end
  endtask

  task automatic rd_issue(input int s, input int b, input int w);
    rd_exp_t e;
    rd_slot = 3'(s);
    rd_bank = b[0];
    rd_addr = 3'(w);
    e.e0 = ref_mem[idx(s, b, w)];
    e.e1 = (b == 0) ? 32'h0 : ref_mem[idx(s, b, w)];
    rdq.push_back(e);
  endtask

  task automatic host_wr(input int s, input int b, input int w, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_slot = 3'(s);
    wr_bank = b[0];
    wr_addr = 3'(w);
    wr_d    = d;
    tick();
    wr_en = 1'b0;
    ref_mem[idx(s, b, w)]  = d;
    ref_mask[idx(s, b, w)] = 1'b1;
  endtask

  task automatic reset_and_sweep(input string tag);
    int cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear_all();
    cnt = busy0 ? 1 : 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!busy0) break;
      cnt++;
    end
    check(tag, 256'(cnt), 256'd128);
    check("zdone_after_zall", zdone0, 1'b1);
    tick();
    check("zdone_pulse_end", zdone0, 1'b0);
  endtask

  task automatic read_slot(input int s);
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < 8; w++) begin
        rd_issue(s, b, w);
        tick();
      end
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; wr_en = 1'b0; wr_bank = 1'b0; rd_bank = 1'b0; ssid_vld = 1'b0;
    ecdh_sk_update = 1'b0; zeroize_req = 1'b0; zeroize_all = 1'b0;
    wr_slot = '0; wr_addr = '0; rd_slot = '0; rd_addr = '0; ssid = '0;
    zeroize_slot = '0; wr_d = '0; ecdh_sk = '0;
    model_clear_all();

    // Reset: full sweep, everything invalid and zero.
    reset_and_sweep("busy_cycles_reset");
    ssid_vld = 1'b1;
    tick();
    check("k_vld_after_reset", k_vld0, 1'b0);
    check("psk_vld_after_reset", psk_vld0, 1'b0);
    check("k_after_reset", k0, '0);
    for (int s = 0; s < 8; s++) read_slot(s);

    // Partial then complete KEY provisioning of slot 3.
    ssid = 3'd3;
    for (int w = 0; w < 7; w++) host_wr(3, 0, w, 32'h11111111 * (w + 1));
    tick();
    tick();
    check("k_vld_partial", k_vld0, 1'b0);
    check("k_partial", k0, '0);
    host_wr(3, 0, 7, 32'h88888888);
    check("k_vld_write_edge", k_vld0, 1'b0);
    tick();
    check("k_vld_complete", k_vld0, 1'b1);
    check("k_complete", k0, exp_bank(3, 0));
    check("psk_vld_slot3", psk_vld0, 1'b0);
    check("wr_err_idle", wr_err0, 1'b0);
    rd_issue(3, 0, 2);
    tick();

    // Read-during-write returns the old word, then the new one.
    rd_issue(6, 1, 2);
    wr_en = 1'b1; wr_slot = 3'd6; wr_bank = 1'b1; wr_addr = 3'd2; wr_d = 32'hCAFEF00D;
    tick();
    wr_en = 1'b0;
    ref_mem[idx(6, 1, 2)] = 32'hCAFEF00D;
    ref_mask[idx(6, 1, 2)] = 1'b1;
    rd_issue(6, 1, 2);
    tick();

    // ECDH update of slot 5 PSK.
    ssid = 3'd5;
    ecdh_sk = {8{32'hA5A5A5A5}};
    ecdh_sk_update = 1'b1;
    tick();
    check("ecdh_ack", ecdh_ack0, 1'b1);
    ecdh_sk_update = 1'b0;
    for (int w = 0; w < 8; w++) begin
      ref_mem[idx(5, 1, w)]  = 32'hA5A5A5A5;
      ref_mask[idx(5, 1, w)] = 1'b1;
    end
    tick();
    check("ecdh_ack_pulse", ecdh_ack0, 1'b0);
    check("psk_vld_ecdh", psk_vld0, 1'b1);
    check("psk_ecdh", psk0, exp_bank(5, 1));
    check("k_vld_slot5", k_vld0, 1'b0);
    check("k_slot5", k0, '0);

    // ECDH held off while host writes.
    ecdh_sk = {8{32'h5A5A5A5A}};
    ecdh_sk_update = 1'b1;
    wr_en = 1'b1; wr_slot = 3'd6; wr_bank = 1'b0; wr_addr = 3'd0; wr_d = 32'h01234567;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ecdh_blocked_by_wr", ecdh_ack0, 1'b0);
    end
    wr_en = 1'b0;
    ref_mem[idx(6, 0, 0)] = 32'h01234567;
    ref_mask[idx(6, 0, 0)] = 1'b1;
    tick();
    check("ecdh_ack_after_wr", ecdh_ack0, 1'b1);
    ecdh_sk_update = 1'b0;
    for (int w = 0; w < 8; w++) ref_mem[idx(5, 1, w)] = 32'h5A5A5A5A;
    tick();
    check("psk_ecdh2", psk0, exp_bank(5, 1));
    rd_issue(6, 0, 0);
    tick();

    // Zeroize slot 3 with a write on the accept cycle and one mid-sweep.
    ssid = 3'd3;
    tick();
    check("k_vld_pre_zero", k_vld0, 1'b1);
    zeroize_req = 1'b1; zeroize_all = 1'b0; zeroize_slot = 3'd3;
    wr_en = 1'b1; wr_slot = 3'd6; wr_bank = 1'b0; wr_addr = 3'd1; wr_d = 32'hBAD0BAD0;
    tick();
    zeroize_req = 1'b0;
    wr_en = 1'b0;
    check("wr_err_accept", wr_err0, 1'b1);
    cnt = busy0 ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 2) begin
        wr_en = 1'b1; wr_slot = 3'd5; wr_bank = 1'b1; wr_addr = 3'd0; wr_d = 32'hDEADBEEF;
      end
      if (i == 4) begin
        zeroize_req = 1'b1; zeroize_all = 1'b1;
      end
      tick();
      zeroize_req = 1'b0;
      zeroize_all = 1'b0;
      if (i == 0) check("k_vld_zero_accept", k_vld0, 1'b0);
      if (i == 2) begin
        check("wr_err_busy", wr_err0, 1'b1);
        wr_en = 1'b0;
      end
      if (i == 3) check("wr_err_pulse_end", wr_err0, 1'b0);
      if (!busy0) break;
      cnt++;
    end
    check("busy_cycles_zslot", 256'(cnt), 256'd16);
    check("zdone_zslot", zdone0, 1'b1);
    model_clear_slot(3);
    tick();
    check("zdone_zslot_end", zdone0, 1'b0);
    check("k_vld_post_zero", k_vld0, 1'b0);
    read_slot(3);
    read_slot(5);
    rd_issue(6, 0, 1);
    tick();

    // Reset mid-ZSLOT restarts a full sweep.
    ssid = 3'd5;
    zeroize_req = 1'b1; zeroize_slot = 3'd5;
    tick();
    zeroize_req = 1'b0;
    repeat (5) tick();
    check("busy_mid_zslot", busy0, 1'b1);
    reset_and_sweep("busy_cycles_rst_mid");
    check("psk_vld_after_rst", psk_vld0, 1'b0);
    rd_issue(5, 1, 0);
    tick();
    rd_issue(6, 1, 2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
